// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for SDIV/UDIV.
// Fixed latency: one capture edge, WIDTH iteration edges, one fix-up edge.
module iterative_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    input  logic [3:0]       WA_in,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic [3:0]       WA_out
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t state;
    state_t state_n;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] dvd;
    logic [3:0]       wa;
    logic             qsign;
    logic             rsign;
    logic             dzero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             last;

    always_comb begin
        a_mag   = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
        b_mag   = (Signed && Divisor[WIDTH-1]) ? -Divisor : Divisor;
        shifted = {p, q[WIDTH-1]};
        // P_shifted < 2*D, so WIDTH+1 bits hold the trial and its sign
        trial   = shifted - {1'b0, d};
        last    = (count == CW'(WIDTH - 1));
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (Start) state_n = RUN;
            RUN:     if (last) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Quotient  <= '0;
            Remainder <= '0;
            WA_out    <= '0;
            count     <= '0;
            p         <= '0;
            q         <= '0;
            d         <= '0;
            dvd       <= '0;
            wa        <= '0;
            qsign     <= 1'b0;
            rsign     <= 1'b0;
            dzero     <= 1'b0;
        end else begin
            Busy <= (state_n != IDLE);
            Done <= (state == FIX);
            unique case (state)
                IDLE: begin
                    if (Start) begin
                        q     <= a_mag;
                        d     <= b_mag;
                        p     <= '0;
                        count <= '0;
                        dvd   <= Dividend;
                        wa    <= WA_in;
                        qsign <= Signed &
                                 (Dividend[WIDTH-1] ^ Divisor[WIDTH-1]);
                        rsign <= Signed & Dividend[WIDTH-1];
                        dzero <= (Divisor == '0);
                    end
                end
                RUN: begin
                    q     <= {q[WIDTH-2:0], ~trial[WIDTH]};
                    p     <= trial[WIDTH] ? shifted[WIDTH-1:0]
                                          : trial[WIDTH-1:0];
                    count <= count + CW'(1);
                end
                FIX: begin
                    // Zero divisor follows ARM: quotient 0, dividend back
                    if (dzero) begin
                        Quotient  <= '0;
                        Remainder <= dvd;
                    end else begin
                        Quotient  <= qsign ? -q : q;
                        Remainder <= rsign ? -p : p;
                    end
                    WA_out <= wa;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: latency, results, ignore/back-to-back,
// and asynchronous reset abort.
module tb_iterative_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic        Signed;
    logic [31:0] Dividend;
    logic [31:0] Divisor;
    logic [3:0]  WA_in;
    logic        Busy;
    logic        Done;
    logic [31:0] Quotient;
    logic [31:0] Remainder;
    logic [3:0]  WA_out;

    int n_checks = 0;
    int n_pass   = 0;

    iterative_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .Start     (Start),
        .Signed    (Signed),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .WA_in     (WA_in),
        .Busy      (Busy),
        .Done      (Done),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .WA_out    (WA_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    typedef struct {
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  wa;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[$] = '{
        '{1'b0, 32'd10,        32'd5,         4'd3,  32'd2,         32'd0},
        '{1'b1, 32'hFFFFFFF9,  32'd2,         4'd1,  32'hFFFFFFFD,  32'hFFFFFFFF},
        '{1'b1, 32'd7,         32'hFFFFFFFE,  4'd2,  32'hFFFFFFFD,  32'd1},
        '{1'b0, 32'hFFFFFFFF,  32'h10,        4'd4,  32'h0FFFFFFF,  32'hF},
        '{1'b0, 32'h1234,      32'd0,         4'd5,  32'd0,         32'h1234},
        '{1'b1, 32'h80000000,  32'hFFFFFFFF,  4'd6,  32'h80000000,  32'd0},
        '{1'b1, 32'hFFFFFFF0,  32'd0,         4'd7,  32'd0,         32'hFFFFFFF0},
        '{1'b0, 32'h80000000,  32'hFFFFFFFF,  4'd8,  32'd0,         32'h80000000},
        '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'd9,  32'd1,         32'd0},
        '{1'b1, 32'h7FFFFFFF,  32'd1,         4'd10, 32'h7FFFFFFF,  32'd0},
        '{1'b1, 32'h80000000,  32'd2,         4'd11, 32'hC0000000,  32'd0},
        '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  4'd12, 32'd1,         32'd0},
        '{1'b1, 32'hFFFFFF9C,  32'd7,         4'd13, 32'hFFFFFFF2,  32'hFFFFFFFE},
        '{1'b0, 32'd0,         32'd7,         4'd14, 32'd0,         32'd0},
        '{1'b1, 32'h7FFFFFFF,  32'h80000000,  4'd15, 32'd0,         32'h7FFFFFFF}
    };

    // Counts edges (sampled #1 after each) until Done, bounded
    task automatic wait_done(output int n, output int busy_n);
        n = 0;
        busy_n = 0;
        while (!Done && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (Busy) busy_n++;
        end
    endtask

    task automatic drive(input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] wa);
        Signed   = sg;
        Dividend = a;
        Divisor  = b;
        WA_in    = wa;
    endtask

    int lat;
    int bc;
    int seen;

    initial begin
        reset = 1'b1;
        Start = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_q", Quotient, 32'd0);
        check("rst_r", Remainder, 32'd0);
        check("rst_wa", 32'(WA_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].wa);
            Start = 1'b1;
            @(posedge clk);
            #1;
            Start = 1'b0;
            bc = Busy ? 1 : 0;
            wait_done(lat, seen);
            bc += seen;
            check($sformatf("lat%0d", i), 32'(lat), 32'd33);
            check($sformatf("busy%0d", i), 32'(bc), 32'd33);
            check($sformatf("q%0d", i), Quotient, vecs[i].q);
            check($sformatf("r%0d", i), Remainder, vecs[i].r);
            check($sformatf("wa%0d", i), 32'(WA_out), 32'(vecs[i].wa));
            @(posedge clk);
            #1;
            check($sformatf("pulse%0d", i), 32'(Done), 32'd0);
        end

        // Start during a run must be ignored
        @(negedge clk);
        drive(1'b0, 32'd100, 32'd7, 4'd2);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        lat = 0;
        while (!Done && lat < 100) begin
            if (lat == 5 || lat == 20) begin
                drive(1'b1, 32'd1, 32'd1, 4'd9);
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        Start = 1'b0;
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_q", Quotient, 32'd14);
        check("ign_r", Remainder, 32'd2);
        check("ign_wa", 32'(WA_out), 32'd2);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Done) seen++;
        end
        check("ign_nodone", 32'(seen), 32'd0);

        // Start held through Done gives back-to-back operations
        @(negedge clk);
        drive(1'b0, 32'd50, 32'd5, 4'd1);
        Start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat, seen);
        check("b2b_lat1", 32'(lat), 32'd33);
        check("b2b_q1", Quotient, 32'd10);
        check("b2b_r1", Remainder, 32'd0);
        drive(1'b0, 32'd9, 32'd4, 4'd8);
        @(posedge clk);
        #1;
        Start = 1'b0;
        check("b2b_busy", 32'(Busy), 32'd1);
        lat = 1;
        while (!Done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("b2b_lat2", 32'(lat), 32'd34);
        check("b2b_q2", Quotient, 32'd2);
        check("b2b_r2", Remainder, 32'd1);
        check("b2b_wa2", 32'(WA_out), 32'd8);

        // Asynchronous reset in mid-run
        @(negedge clk);
        drive(1'b0, 32'd1000, 32'd3, 4'd5);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (16) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_busy", 32'(Busy), 32'd0);
        check("arst_done", 32'(Done), 32'd0);
        check("arst_q", Quotient, 32'd0);
        check("arst_r", Remainder, 32'd0);
        check("arst_wa", 32'(WA_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Done || Busy) seen++;
        end
        check("arst_idle", 32'(seen), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'd77, 32'd7, 4'd9);
        Start = 1'b1;
        @(posedge clk);
        #1;
        Start = 1'b0;
        wait_done(lat, seen);
        check("post_lat", 32'(lat), 32'd33);
        check("post_q", Quotient, 32'd11);
        check("post_r", Remainder, 32'd0);
        check("post_wa", 32'(WA_out), 32'd9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle 32-bit integer divider serving the SDIV (ALUControl 3'b101) and UDIV (3'b110) operations of the single-cycle datapath ALU. It takes register-file operands RD1 (dividend) and RD2 (divisor) plus the destination register address, and runs a 32-iteration restoring division. It returns quotient, remainder and the captured destination address to the write-back path with a one-cycle Done pulse. The control unit stalls the datapath while Busy is high.

## Interface
- WIDTH, 32, operand/result width in bits; the iteration count equals WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- Start  in  1  request a division; sampled only when Busy=0.
- Signed  in  1  1 = SDIV (two's complement), 0 = UDIV; captured with Start.
- Dividend  in  WIDTH  RD1 operand; captured with Start.
- Divisor  in  WIDTH  RD2 operand; captured with Start.
- WA_in  in  4  destination register address; captured with Start.
- Busy  out  1  high from the cycle after Start is accepted until the result is posted.
- Done  out  1  one-cycle pulse; Quotient/Remainder/WA_out are valid in that cycle.
- Quotient  out  WIDTH  result quotient; holds until the next completion.
- Remainder  out  WIDTH  result remainder; holds until the next completion.
- WA_out  out  4  captured destination address; holds until the next completion.

## Operation
- States: IDLE, RUN, FIX.
- IDLE → RUN on Start. Capture:
  - |Dividend| and |Divisor| if Signed, raw values otherwise;
  - sign of quotient = Dividend[31]^Divisor[31] (Signed only);
  - sign of remainder = Dividend[31] (Signed only);
  - WA_in, and a divisor-is-zero flag.
  - Clear partial remainder P and iteration counter.
- RUN, one iteration per cycle:
  - shift {P, Q} left by 1 and form T = P_shifted − D, computed WIDTH+1 bits wide;
  - if T ≥ 0, P = T and Q[0] = 1; otherwise P is kept and Q[0] = 0.
  - After WIDTH iterations → FIX.
- FIX, one cycle, registers the outputs:
  - Quotient = negate-if(qsign, Q); Remainder = negate-if(rsign, P). Truncating division; the remainder carries the sign of the dividend.
  - Divisor zero: Quotient = 0, Remainder = original Dividend. This is the ARM convention and takes no trap.
  - SDIV 0x80000000 / 0xFFFFFFFF: Quotient = 0x80000000, Remainder = 0. This falls out of the magnitude path with wrap-around negation and needs no special case beyond the width rule above.
  - Asserts Done, deasserts Busy, then → IDLE.
- Start while Busy=1 is ignored; operands are not re-captured.
- Start in the cycle Done is high is accepted, giving back-to-back operations.
- Unsigned operands use all 32 bits; 0xFFFFFFFF is a valid dividend or divisor.

## Timing
- Reset values: Busy=0, Done=0, Quotient=0, Remainder=0, WA_out=0, state IDLE, counter 0.
- Reset asserted mid-RUN aborts the operation immediately (asynchronously). No Done is produced, and the prior results are cleared to 0.
- Edge E0 samples Start=1: Busy=1 after E0.
- Edges E1..E32 perform iterations 1..32 (WIDTH edges).
- Edge E33 (FIX) registers the results: Done=1 and Busy=0 after E33.
- Done returns to 0 after E34 unless a new completion occurs then, which is impossible (minimum spacing 34 cycles).
- Latency from the Start-sampling edge to the Done cycle is 33 edges; throughput is one operation per 34 cycles.
- Fixed latency applies to all operand values, including a zero divisor.

## Test plan
- UDIV 10/5, WA_in=3 → Done exactly 33 edges after the Start edge; Quotient=2, Remainder=0, WA_out=3; Busy high for 33 cycles.
- SDIV −7/2 → Quotient=0xFFFFFFFD (−3), Remainder=0xFFFFFFFF (−1). SDIV 7/−2 → −3, rem 1. UDIV 0xFFFFFFFF/0x10 → 0x0FFFFFFF, rem 0xF.
- Divide by zero: UDIV 0x1234/0 → Quotient=0, Remainder=0x1234. SDIV 0x80000000/0xFFFFFFFF → Quotient=0x80000000, Remainder=0.
- Start pulsed at cycles 5 and 20 of an active run with different operands → only the first result is produced, with no corruption; Start held high at Done → second operation starts, its Done arrives 34 cycles after the first.
- Reset asserted at iteration 16 between clock edges → Busy, Done and outputs go to 0 without waiting for a clock edge; no Done follows. A new Start after reset release completes normally.
- Random 10k-operation regression against a signed/unsigned reference model, including all corner operands (0, 1, −1, 0x7FFFFFFF, 0x80000000).
